base64_decoder: RTL and testbench

BASE64_DECODER -- requirements
Module: base64_decoder

---
 rtl/base64_pkg.sv | 32 +++
 rtl/base64_char_decode.sv | 32 +++
 rtl/base64_decoder.sv | 145 ++++++++++++++
 tb/tb_base64_decoder.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/base64_pkg.sv
// Shared types and constants for the Base64 decoder: FSM encoding, special
// characters and the per-character classification record.
package base64_pkg;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    EMIT    = 2'd1,
    ERROR   = 2'd2
  } state_t;

  localparam logic [7:0] PAD_CHAR = 8'h3D;
  localparam logic [7:0] CR_CHAR  = 8'h0D;
  localparam logic [7:0] LF_CHAR  = 8'h0A;
  localparam int         SEXTET_W = 6;

  typedef struct packed {
    logic [SEXTET_W-1:0] sextet;
    logic                is_pad;
    logic                is_skip;
    logic                is_invalid;
  } char_class_t;

  // Byte idx of a decoded quad, most significant first.
  function automatic logic [7:0] quad_byte(input logic [23:0] acc, input logic [1:0] idx);
    case (idx)
      2'd0:    quad_byte = acc[23:16];
      2'd1:    quad_byte = acc[15:8];
      default: quad_byte = acc[7:0];
    endcase
  endfunction

endpackage

// File: rtl/base64_char_decode.sv
// Combinational classification of one ASCII character into a Base64 sextet,
// pad, line-break skip, or invalid.
module base64_char_decode
  import base64_pkg::*;
(
  input  logic [7:0]  ch,
  output char_class_t cls
);

  always_comb begin
    cls = '0;
    if (ch >= 8'h41 && ch <= 8'h5A) begin
      cls.sextet = SEXTET_W'(ch - 8'h41);
    end else if (ch >= 8'h61 && ch <= 8'h7A) begin
      // 'a' (0x61) lands on 26
      cls.sextet = SEXTET_W'(ch - 8'h47);
    end else if (ch >= 8'h30 && ch <= 8'h39) begin
      cls.sextet = SEXTET_W'(ch + 8'h04);
    end else if (ch == 8'h2B) begin
      cls.sextet = 6'd62;
    end else if (ch == 8'h2F) begin
      cls.sextet = 6'd63;
    end else if (ch == PAD_CHAR) begin
      cls.is_pad = 1'b1;
    end else if (ch == CR_CHAR || ch == LF_CHAR) begin
      cls.is_skip = 1'b1;
    end else begin
      cls.is_invalid = 1'b1;
    end
  end

endmodule

// File: rtl/base64_decoder.sv
// Streaming Base64 decoder: gathers four characters into a 24-bit quad, then
// emits 1-3 bytes with valid/ready handshaking on both sides.
//
// state   | meaning
// COLLECT | accepting characters, shifting sextets into the accumulator
// EMIT    | presenting decoded bytes of the completed quad, input stalled
// ERROR   | sticky decode error, input accepted and discarded until reset
module base64_decoder
  import base64_pkg::*;
#(
  parameter int STRICT_LAST = 1
) (
  input  logic       Clk,
  input  logic       Resetn,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_char,
  input  logic       in_last,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_byte,
  output logic       out_last,
  output logic       err,
  output logic [1:0] sextet_cnt
);

  state_t      state_q, state_d;
  logic [23:0] acc_q, acc_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [1:0]  pad_cnt_q, pad_cnt_d;
  logic        after_pad_q, after_pad_d;
  logic [1:0]  nbytes_q, nbytes_d;
  logic [1:0]  idx_q, idx_d;
  logic        last_q, last_d;
  logic        live_q;
  logic [1:0]  pad_total;
  logic        bad_char;
  char_class_t cls;

  base64_char_decode u_char_decode (
    .ch  (in_char),
    .cls (cls)
  );

  assign pad_total = pad_cnt_q + {1'b0, cls.is_pad};

  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      state_q     <= COLLECT;
      acc_q       <= '0;
      cnt_q       <= '0;
      pad_cnt_q   <= '0;
      after_pad_q <= 1'b0;
      nbytes_q    <= '0;
      idx_q       <= '0;
      last_q      <= 1'b0;
      live_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      pad_cnt_q   <= pad_cnt_d;
      after_pad_q <= after_pad_d;
      nbytes_q    <= nbytes_d;
      idx_q       <= idx_d;
      last_q      <= last_d;
      live_q      <= 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    pad_cnt_d   = pad_cnt_q;
    after_pad_d = after_pad_q;
    nbytes_d    = nbytes_q;
    idx_d       = idx_q;
    last_d      = last_q;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    err         = 1'b0;
    bad_char    = 1'b0;

    case (state_q)
      COLLECT: begin
        in_ready = live_q;
        // Line breaks are swallowed without touching any decode state.
        if (in_valid && live_q && !cls.is_skip) begin
          bad_char = cls.is_invalid
                  || after_pad_q
                  || (cls.is_pad && cnt_q < 2'd2)
                  || (!cls.is_pad && pad_cnt_q != 2'd0)
                  || (STRICT_LAST != 0 && in_last && cnt_q != 2'd3);
          if (bad_char) begin
            state_d = ERROR;
          end else begin
            acc_d = {acc_q[17:0], (cls.is_pad ? 6'd0 : cls.sextet)};
            cnt_d = cnt_q + 2'd1;
            if (cls.is_pad) pad_cnt_d = pad_total;
            if (cnt_q == 2'd3) begin
              state_d     = EMIT;
              idx_d       = 2'd0;
              last_d      = in_last;
              nbytes_d    = 2'd3 - pad_total;
              after_pad_d = (pad_total != 2'd0);
              pad_cnt_d   = 2'd0;
            end
          end
        end
      end

      EMIT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          if (idx_q == nbytes_q - 2'd1) begin
            state_d = COLLECT;
            idx_d   = 2'd0;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
      end

      ERROR: begin
        err      = 1'b1;
        in_ready = live_q;
      end

      default: state_d = COLLECT;
    endcase
  end

  always_comb begin
    out_byte = 8'h00;
    out_last = 1'b0;
    if (state_q == EMIT) begin
      out_byte = quad_byte(acc_q, idx_q);
      out_last = last_q && (idx_q == nbytes_q - 2'd1);
    end
  end

  assign sextet_cnt = cnt_q;

endmodule

// File: tb/tb_base64_decoder.sv
// Bench for base64_decoder: a string-level Base64 reference model checked on
// every cycle, plus directed streams with literal expectations.
module tb_base64_decoder;

  logic       Clk = 1'b0;
  logic       Resetn = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_char = 8'h00;
  logic       in_last = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_byte;
  logic       out_last;
  logic       err;
  logic [1:0] sextet_cnt;

  int total = 0;
  int bad = 0;

  base64_decoder #(.STRICT_LAST(1)) dut (
    .Clk        (Clk),
    .Resetn     (Resetn),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_char    (in_char),
    .in_last    (in_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_byte   (out_byte),
    .out_last   (out_last),
    .err        (err),
    .sextet_cnt (sextet_cnt)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: works on whole quads of character values.
  string alphabet = "ABCDEFGHIJKLMNOPQRSTUVWXYZabcdefghijklmnopqrstuvwxyz0123456789+/";
  int         m_pos, m_pads;
  int         m_vals[4];
  bit         m_err, m_after_pad;
  logic [7:0] exp_b[$];
  bit         exp_l[$];

  function automatic int char_value(input logic [7:0] c);
    for (int i = 0; i < 64; i++)
      if (8'(alphabet[i]) == c) return i;
    return -1;
  endfunction

  function automatic void model_reset();
    m_pos = 0; m_pads = 0; m_err = 0; m_after_pad = 0;
    exp_b.delete(); exp_l.delete();
  endfunction

  function automatic void model_feed(input logic [7:0] c, input bit l);
    int v;
    bit pad;
    int word, nb;
    if (m_err) return;
    if (c == 8'h0D || c == 8'h0A) return;
    pad = (c == 8'h3D);
    v = char_value(c);
    if ((!pad && v < 0) || m_after_pad || (pad && m_pos < 2) ||
        (!pad && m_pads > 0) || (l && m_pos != 3)) begin
      m_err = 1;
      return;
    end
    m_vals[m_pos] = pad ? 0 : v;
    if (pad) m_pads++;
    m_pos++;
    if (m_pos == 4) begin
      word = m_vals[0] * 262144 + m_vals[1] * 4096 + m_vals[2] * 64 + m_vals[3];
      nb = 3 - m_pads;
      for (int i = 0; i < nb; i++) begin
        exp_b.push_back(8'((word >> (16 - 8 * i)) & 255));
        exp_l.push_back(l && (i == nb - 1));
      end
      m_after_pad = (m_pads > 0);
      m_pos = 0;
      m_pads = 0;
    end
  endfunction

  logic [7:0] rx_b[$];
  bit         rx_l[$];
  logic [7:0] hold_b;
  bit         hold_l, holding;
  int         ov_seen;

  always @(negedge Clk) begin
    if (!Resetn) begin
      model_reset();
      holding = 0;
    end else begin
      chk("err", int'(err), int'(m_err));
      chk("sextet_cnt", int'(sextet_cnt), m_pos);
      if (out_valid) begin
        ov_seen++;
        chk("in_ready_during_emit", int'(in_ready), 0);
        if (holding) begin
          chk("held_byte", int'(out_byte), int'(hold_b));
          chk("held_last", int'(out_last), int'(hold_l));
        end
        if (exp_b.size() == 0) begin
          chk("spurious_out", int'(exp_b.size() == 0), 0);
        end else if (out_ready) begin
          chk("out_byte", int'(out_byte), int'(exp_b[0]));
          chk("out_last", int'(out_last), int'(exp_l[0]));
          rx_b.push_back(out_byte);
          rx_l.push_back(out_last);
          void'(exp_b.pop_front());
          void'(exp_l.pop_front());
        end
        holding = !out_ready;
        hold_b  = out_byte;
        hold_l  = out_last;
      end else begin
        holding = 0;
      end
      if (in_valid && in_ready) model_feed(in_char, in_last);
    end
  end

  // All stimulus changes happen 1 time unit after a rising edge.
  task automatic send(input logic [7:0] c, input bit l);
    int n = 0;
    in_valid = 1'b1; in_char = c; in_last = l;
    while (!in_ready && n < 100) begin
      @(posedge Clk); #1;
      n++;
    end
    chk("in_ready_wait", int'(n >= 100), 0);
    @(posedge Clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic send_str(input string s, input bit last_final);
    for (int i = 0; i < s.len(); i++)
      send(8'(s[i]), last_final && (i == s.len() - 1));
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_b.size() != 0 || out_valid) && n < 100) begin
      @(posedge Clk); #1;
      n++;
    end
    chk("drain_left", int'(exp_b.size()), 0);
  endtask

  task automatic expect_rx(input string name, input logic [7:0] b0, input logic [7:0] b1,
                           input logic [7:0] b2, input int n, input bit final_last);
    logic [7:0] want;
    chk({name, "_count"}, rx_b.size(), n);
    for (int i = 0; i < n && i < rx_b.size(); i++) begin
      want = (i == 0) ? b0 : (i == 1) ? b1 : b2;
      chk({name, "_byte"}, int'(rx_b[i]), int'(want));
      chk({name, "_last"}, int'(rx_l[i]), int'(final_last && i == n - 1));
    end
    rx_b.delete(); rx_l.delete();
  endtask

  task automatic do_reset(input bit check);
    Resetn = 1'b0; in_valid = 1'b0;
    #1;
    if (check) begin
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_out_byte", int'(out_byte), 0);
      chk("rst_out_last", int'(out_last), 0);
      chk("rst_err", int'(err), 0);
      chk("rst_sextet_cnt", int'(sextet_cnt), 0);
      chk("rst_in_ready", int'(in_ready), 0);
    end
    repeat (2) @(posedge Clk);
    #1;
    Resetn = 1'b1;
    #1;
    if (check) chk("release_in_ready_low", int'(in_ready), 0);
    @(posedge Clk); #1;
    if (check) chk("release_in_ready_high", int'(in_ready), 1);
    rx_b.delete(); rx_l.delete();
    ov_seen = 0;
  endtask

  initial begin
    #2;
    do_reset(1);
    out_ready = 1'b1;

    send_str("TWFu", 1);
    drain();
    expect_rx("twfu", 8'h4D, 8'h61, 8'h6E, 3, 1);

    do_reset(0);
    send_str("TWE=", 1);
    drain();
    expect_rx("twe_pad", 8'h4D, 8'h61, 8'h00, 2, 1);

    do_reset(0);
    send_str("TQ==", 1);
    drain();
    expect_rx("tq_pad2", 8'h4D, 8'h00, 8'h00, 1, 1);

    do_reset(0);
    send_str("TW", 0);
    chk("cnt_before_cr", int'(sextet_cnt), 2);
    send(8'h0D, 0);
    chk("cnt_after_cr", int'(sextet_cnt), 2);
    send(8'h0A, 0);
    chk("cnt_after_lf", int'(sextet_cnt), 2);
    send_str("Fu", 1);
    drain();
    expect_rx("crlf", 8'h4D, 8'h61, 8'h6E, 3, 1);

    do_reset(0);
    out_ready = 1'b0;
    send_str("TWFu", 1);
    chk("stall_first_valid", int'(out_valid), 1);
    chk("stall_first_byte", int'(out_byte), 8'h4D);
    out_ready = 1'b1;
    @(posedge Clk); #1;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("stall_byte", int'(out_byte), 8'h61);
      chk("stall_in_ready", int'(in_ready), 0);
      chk("stall_valid", int'(out_valid), 1);
      @(posedge Clk); #1;
    end
    out_ready = 1'b1;
    drain();
    expect_rx("stall", 8'h4D, 8'h61, 8'h6E, 3, 1);

    do_reset(0);
    send_str("T*", 0);
    chk("bad_char_err", int'(err), 1);
    repeat (3) @(posedge Clk);
    #1;
    chk("bad_char_no_out", ov_seen, 0);

    do_reset(0);
    send_str("=AAA", 0);
    chk("lead_pad_err", int'(err), 1);
    chk("lead_pad_no_out", ov_seen, 0);

    do_reset(0);
    send_str("TWFu", 1);
    @(posedge Clk); #1;
    expect_rx("pre_reset", 8'h4D, 8'h00, 8'h00, 1, 0);
    do_reset(1);
    send_str("TQ==", 1);
    drain();
    repeat (3) @(posedge Clk);
    #1;
    expect_rx("post_reset", 8'h4D, 8'h00, 8'h00, 1, 1);

    do_reset(0);
    send_str("TW", 1);
    chk("early_last_err", int'(err), 1);

    do_reset(0);
    send_str("TQ==", 0);
    drain();
    send_str("T", 0);
    chk("after_pad_err", int'(err), 1);
    expect_rx("after_pad", 8'h4D, 8'h00, 8'h00, 1, 0);

    do_reset(0);
    send_str("SGVsbG8h", 1);
    drain();
    chk("hello_count", rx_b.size(), 6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
